// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU unit for the EX stage.
// Holds the pipeline through the operation and returns {HI,LO} with a one-cycle pulse.
module muldiv_seq #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic                flush,
  output logic                stall_o,
  output logic                res_valid,
  output logic [2*DATA_W-1:0] res
);

  localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, DIV_RUN, MUL_RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sgn_q, sgn_d;
  logic [DATA_W-1:0]     a_q, a_d;
  logic [DATA_W-1:0]     b_q, b_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]     quot_q, quot_d;
  logic [2*DATA_W-1:0]   res_q, res_d;

  logic [DATA_W-1:0]     divisor;
  logic [DATA_W:0]       remShift;
  logic [DATA_W:0]       remDiff;
  logic                  quotBit;
  logic [DATA_W-1:0]     nextRem;
  logic [DATA_W-1:0]     nextQuot;
  logic [DATA_W-1:0]     quotFinal;
  logic [DATA_W-1:0]     remFinal;
  logic [2*DATA_W-1:0]   mulA;
  logic [2*DATA_W-1:0]   mulB;
  logic [2*DATA_W-1:0]   product;

  // Two's-complement magnitude; the most negative value maps to itself, which is
  // still correct when read as unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                   input logic isSigned);
    return (isSigned && v[DATA_W-1]) ? -v : v;
  endfunction

  // Datapath: one restoring-division step on magnitudes plus the sign fixup, and the product.
  always_comb begin
    divisor   = magnitude(b_q, sgn_q);
    remShift  = {rem_q, quot_q[DATA_W-1]};
    remDiff   = remShift - {1'b0, divisor};
    quotBit   = ~remDiff[DATA_W];
    nextRem   = quotBit ? remDiff[DATA_W-1:0] : remShift[DATA_W-1:0];
    nextQuot  = {quot_q[DATA_W-2:0], quotBit};
    quotFinal = (sgn_q && (a_q[DATA_W-1] ^ b_q[DATA_W-1])) ? -nextQuot : nextQuot;
    remFinal  = (sgn_q && a_q[DATA_W-1]) ? -nextRem : nextRem;
    mulA      = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
    mulB      = {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
    product   = mulA * mulB;
  end

  // Next-state logic and combinational stall; flush overrides everything and drops stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    res_d   = res_q;
    stall_o = 1'b0;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            stall_o = 1'b1;
            sgn_d   = ~op[0];
            a_d     = a;
            b_d     = b;
            cnt_d   = '0;
            if (op[1]) begin
              state_d = MUL_RUN;
            end else if (b == '0) begin
              state_d = DONE;
              res_d   = {a, {DATA_W{1'b1}}};
            end else begin
              state_d = DIV_RUN;
              rem_d   = '0;
              quot_d  = magnitude(a, ~op[0]);
            end
          end
        end
        DIV_RUN: begin
          stall_o = 1'b1;
          rem_d   = nextRem;
          quot_d  = nextQuot;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = DONE;
            res_d   = {remFinal, quotFinal};
          end
        end
        MUL_RUN: begin
          stall_o = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
            state_d = DONE;
            res_d   = product;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and operand registers with synchronous reset clearing everything, result included.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      res_q   <= res_d;
    end
  end

  assign res_valid = (state_q == DONE);
  assign res       = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and random checks of muldiv_seq against an arithmetic reference.
module tb_muldiv_seq;

   localparam int DATA_W  = 32;
   localparam int MUL_LAT = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        stall_o;
   logic        res_valid;
   logic [63:0] res;

   int checks;
   int errors;

   muldiv_seq #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .flush     (flush),
      .stall_o   (stall_o),
      .res_valid (res_valid),
      .res       (res)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference result from plain arithmetic on the operation's definition.
   function automatic logic [63:0] modelRes(input logic [1:0] opv, input logic [31:0] x,
                                            input logic [31:0] y);
      longint sx;
      longint sy;
      longint q;
      longint r;
      logic [63:0] ux;
      logic [63:0] uy;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      if (!opv[1] && y == 32'd0) return {x, 32'hFFFF_FFFF};
      case (opv)
         2'b00: begin
            q = sx / sy;
            r = sx % sy;
            p = {r[31:0], q[31:0]};
         end
         2'b01: p = {x % y, x / y};
         2'b10: p = 64'(sx * sy);
         default: p = ux * uy;
      endcase
      return p;
   endfunction

   // Cycle of res_valid counted from the start cycle (cycle 0).
   function automatic int expLat(input logic [1:0] opv, input logic [31:0] y);
      if (opv[1]) return MUL_LAT + 1;
      if (y == 32'd0) return 1;
      return DATA_W + 1;
   endfunction

   task automatic checkVal(input string tag, input logic [63:0] observed,
                           input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] opv, input logic [31:0] x,
                                input logic [31:0] y, input string tag);
      @(negedge clk);
      start = 1'b1;
      op    = opv;
      a     = x;
      b     = y;
      flush = 1'b0;
      #1;
      checkVal({tag, "_startStall"}, 64'(stall_o), 64'd1);
   endtask

   // Waits for res_valid while scrambling a/b, counting latency and stalled cycles.
   task automatic checkOutput(input string tag, input int lat, input logic [63:0] expRes);
      int cyc;
      int stallCnt;
      cyc      = 0;
      stallCnt = 1;
      while (cyc < 80) begin
         @(negedge clk);
         start = 1'b0;
         a     = $urandom;
         b     = $urandom;
         cyc++;
         #1;
         if (res_valid) break;
         if (stall_o) stallCnt++;
      end
      checkVal({tag, "_latency"}, 64'(cyc), 64'(lat));
      checkVal({tag, "_stallCycles"}, 64'(stallCnt), 64'(lat));
      checkVal({tag, "_doneStall"}, 64'(stall_o), 64'd0);
      checkVal({tag, "_res"}, res, expRes);
   endtask

   task automatic runOp(input logic [1:0] opv, input logic [31:0] x, input logic [31:0] y,
                        input string tag);
      applyStimulus(opv, x, y, tag);
      checkOutput(tag, expLat(opv, y), modelRes(opv, x, y));
   endtask

   // Directed scenarios followed by random operations.
   initial begin
      logic [1:0]  rop;
      logic [31:0] rx;
      logic [31:0] ry;
      int          pulses;
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      start  = 1'b0;
      flush  = 1'b0;
      op     = 2'b00;
      a      = '0;
      b      = '0;
      repeat (2) @(negedge clk);
      #1;
      checkVal("reset_stall", 64'(stall_o), 64'd0);
      checkVal("reset_valid", 64'(res_valid), 64'd0);
      checkVal("reset_res", res, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      runOp(2'b01, 32'd100, 32'd7, "divu_100_7");
      checkVal("divu_100_7_const", res, {32'd2, 32'd14});
      runOp(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
      checkVal("div_m7_2_const", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      runOp(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      checkVal("div_ovf_const", res, {32'd0, 32'h8000_0000});
      runOp(2'b10, 32'hFFFF_FFFE, 32'd3, "mult_m2_3");
      checkVal("mult_m2_3_const", res, 64'hFFFF_FFFF_FFFF_FFFA);
      runOp(2'b11, 32'hFFFF_FFFE, 32'd3, "multu_3");
      checkVal("multu_3_const", res, 64'h0000_0002_FFFF_FFFA);
      runOp(2'b01, 32'd5, 32'd0, "divu_by0");
      checkVal("divu_by0_const", res, {32'd5, 32'hFFFF_FFFF});

      // Flush a division in cycle 10; no result may ever appear.
      applyStimulus(2'b00, 32'd1000, 32'd3, "flush_div");
      for (int i = 1; i < 10; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      @(negedge clk);
      flush = 1'b1;
      #1;
      checkVal("flush_stallLow", 64'(stall_o), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      checkVal("flush_nextStall", 64'(stall_o), 64'd0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (res_valid) pulses++;
      end
      checkVal("flush_noPulse", 64'(pulses), 64'd0);
      runOp(2'b01, 32'd9, 32'd3, "divu_9_3");
      checkVal("divu_9_3_const", res, {32'd0, 32'd3});

      // Back-to-back: MULTU issued in the DONE cycle of a MULT.
      applyStimulus(2'b10, 32'hFFFF_FFFE, 32'd3, "b2b_first");
      for (int i = 1; i < MUL_LAT + 1; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      @(negedge clk);
      start = 1'b1;
      op    = 2'b11;
      a     = 32'd2;
      b     = 32'd3;
      #1;
      checkVal("b2b_firstValid", 64'(res_valid), 64'd1);
      checkVal("b2b_firstRes", res, 64'hFFFF_FFFF_FFFF_FFFA);
      checkVal("b2b_acceptStall", 64'(stall_o), 64'd1);
      checkOutput("b2b_second", MUL_LAT + 1, 64'd6);

      // Reset in the middle of MUL_RUN clears every output.
      applyStimulus(2'b10, 32'd5, 32'd7, "rst_mul");
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkVal("rstMid_stall", 64'(stall_o), 64'd0);
      checkVal("rstMid_valid", 64'(res_valid), 64'd0);
      checkVal("rstMid_res", res, 64'd0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         if (res_valid) pulses++;
      end
      checkVal("rstMid_noPulse", 64'(pulses), 64'd0);

      // Random operations, biased toward zero, small and overflow divisors.
      for (int i = 0; i < 24; i++) begin
         rop = 2'($urandom_range(0, 3));
         rx  = $urandom;
         ry  = $urandom;
         case ($urandom_range(0, 7))
            0: ry = 32'd0;
            1: ry = ry & 32'h0000_000F;
            2: begin
               rx = 32'h8000_0000;
               ry = 32'hFFFF_FFFF;
            end
            3: rx = rx & 32'h0000_00FF;
            default: ;
         endcase
         runOp(rop, rx, ry, $sformatf("rand%0d_op%0d", i, rop));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
